// File: rtl/umac_array.sv
// rtl/umac_array.sv - multi-lane two-stage multiply-accumulate with dot-product task and sticky overflow
// Optional build macro: UMAC_SAT_EN (clamp accumulators on overflow instead of wrapping).
module umac_array #(
  parameter int LANES = 2,
  parameter int DW    = 16,
  parameter int AW    = 40
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [LANES*DW-1:0]   i_a,
  input  logic [LANES*DW-1:0]   i_b,
  input  logic [1:0]            i_task,
  input  logic                  i_mode,
  input  logic                  i_clr,
  output logic [LANES*AW-1:0]   o_out,
  output logic                  o_valid,
  output logic [LANES-1:0]      o_ovf
);

  localparam int PW = 2*DW;
  // Extra bits hold the exact result of acc plus up to eight products, so overflow is a range test.
  localparam int EW = AW + 4;

  typedef enum logic [1:0] {
    T_MUL = 2'b00,
    T_ACC = 2'b01,
    T_SUB = 2'b10,
    T_DOT = 2'b11
  } task_e;

  logic [PW-1:0]    prod     [LANES];
  logic [PW-1:0]    p_q      [LANES];
  task_e            task_q;
  logic             mode_q;
  logic             s1_valid;
  logic [AW-1:0]    acc      [LANES];
  logic [AW-1:0]    acc_d    [LANES];
  logic [EW-1:0]    base     [LANES];
  logic [EW-1:0]    res      [LANES];
  logic [EW-1:0]    dot_sum;
  logic [LANES-1:0] upd;
  logic [LANES-1:0] hit;
  logic [LANES-1:0] ovf_d;

  function automatic logic [EW-1:0] ext_p(input logic [PW-1:0] v, input logic sgn);
    return sgn ? {{(EW-PW){v[PW-1]}}, v} : {{(EW-PW){1'b0}}, v};
  endfunction

  function automatic logic [EW-1:0] ext_a(input logic [AW-1:0] v, input logic sgn);
    return sgn ? {{(EW-AW){v[AW-1]}}, v} : {{(EW-AW){1'b0}}, v};
  endfunction

`ifdef UMAC_SAT_EN
  function automatic logic [AW-1:0] sat_val(input logic neg, input logic sgn);
    if (sgn)
      return neg ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    return neg ? {AW{1'b0}} : {AW{1'b1}};
  endfunction
`endif

  // Operands are widened to the product width first so the low PW bits are the exact product.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      if (i_mode)
        prod[k] = {{DW{i_a[k*DW+DW-1]}}, i_a[k*DW +: DW]} * {{DW{i_b[k*DW+DW-1]}}, i_b[k*DW +: DW]};
      else
        prod[k] = {{DW{1'b0}}, i_a[k*DW +: DW]} * {{DW{1'b0}}, i_b[k*DW +: DW]};
    end
  end

  always_comb begin
    dot_sum = '0;
    for (int k = 0; k < LANES; k++)
      dot_sum = dot_sum + ext_p(p_q[k], mode_q);

    for (int k = 0; k < LANES; k++) begin
      // A coincident clear is applied before the S2 operation.
      base[k]  = i_clr ? '0 : ext_a(acc[k], mode_q);
      res[k]   = base[k];
      upd[k]   = 1'b0;
      if (s1_valid) begin
        case (task_q)
          T_MUL: begin res[k] = ext_p(p_q[k], mode_q);           upd[k] = 1'b1; end
          T_ACC: begin res[k] = base[k] + ext_p(p_q[k], mode_q); upd[k] = 1'b1; end
          T_SUB: begin res[k] = base[k] - ext_p(p_q[k], mode_q); upd[k] = 1'b1; end
          T_DOT: begin
            if (k == 0) begin
              res[k] = base[k] + dot_sum;
              upd[k] = 1'b1;
            end
          end
        endcase
      end

      if (mode_q)
        hit[k] = upd[k] && !((&res[k][EW-1:AW-1]) || !(|res[k][EW-1:AW-1]));
      else
        hit[k] = upd[k] && (|res[k][EW-1:AW]);

      acc_d[k] = i_clr ? '0 : acc[k];
      if (upd[k]) begin
`ifdef UMAC_SAT_EN
        acc_d[k] = hit[k] ? sat_val(res[k][EW-1], mode_q) : res[k][AW-1:0];
`else
        acc_d[k] = res[k][AW-1:0];
`endif
      end
      ovf_d[k] = (i_clr ? 1'b0 : o_ovf[k]) | hit[k];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      task_q   <= T_MUL;
      mode_q   <= 1'b0;
      o_valid  <= 1'b0;
      o_ovf    <= '0;
      for (int k = 0; k < LANES; k++) begin
        p_q[k] <= '0;
        acc[k] <= '0;
      end
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        task_q <= task_e'(i_task);
        mode_q <= i_mode;
        for (int k = 0; k < LANES; k++)
          p_q[k] <= prod[k];
      end
      o_valid <= s1_valid;
      o_ovf   <= ovf_d;
      for (int k = 0; k < LANES; k++)
        acc[k] <= acc_d[k];
    end
  end

  always_comb begin
    o_out = '0;
    for (int k = 0; k < LANES; k++)
      o_out[k*AW +: AW] = acc[k];
  end

endmodule
